ucie_ctl_sb_tx: RTL and testbench

Sideband transmit path of the UCIe controller RDI config interface, mirroring the sideband receiver on the far end. It accepts a 5-bit RDI message decode and an optional 32-bit advertised-capability value from the controller FSMs. It builds a 64-bit sideband header, plus a 64-bit data phase for capability messages, with control and data parity. It serializes the packet onto the N-bit lp_cfg bus under credit-based flow control driven by the remote cfg_crd returns.

---
 rtl/ucie_ctl_sb_pkg.sv | 62 ++++++
 rtl/ucie_ctl_sb_tx_serializer.sv | 38 +++
 rtl/ucie_ctl_sb_tx.sv | 118 +++++++++++
 tb/tb_ucie_ctl_sb_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_sb_pkg.sv
// Shared sideband definitions: opcodes, endpoint ids, RDI decode table, header layout.
// Pure definitions, no timing.
// The receiver's decoder imports this too, so field positions live only here.
package ucie_ctl_sb_pkg;

    localparam logic [4:0] MSG_NODATA = 5'b10010;
    localparam logic [4:0] MSG_DATA   = 5'b11011;
    localparam logic [2:0] SB_SRCID   = 3'b001;
    localparam logic [2:0] SB_DSTID   = 3'b101;

    localparam logic [4:0] DEC_REQ_ACTIVE    = 5'd1;
    localparam logic [4:0] DEC_REQ_L1        = 5'd2;
    localparam logic [4:0] DEC_RSP_ACTIVE    = 5'd3;
    localparam logic [4:0] DEC_REQ_LINKRESET = 5'd4;
    localparam logic [4:0] DEC_RSP_L1        = 5'd5;
    localparam logic [4:0] DEC_ADV_CAP       = 5'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic        supported;
        logic        has_data;
        logic [7:0]  msgcode;
        logic [7:0]  msgsubcode;
        logic [15:0] msginfo;
    } sb_dec_t;

    function automatic sb_dec_t sb_decode(input logic [4:0] dec);
        sb_dec_t d;
        d = '0;
        case (dec)
            DEC_REQ_ACTIVE:    d = '{1'b1, 1'b0, 8'h01, 8'h01, 16'h0000};
            DEC_REQ_L1:        d = '{1'b1, 1'b0, 8'h01, 8'h04, 16'h0000};
            DEC_RSP_ACTIVE:    d = '{1'b1, 1'b0, 8'h02, 8'h01, 16'h0000};
            DEC_REQ_LINKRESET: d = '{1'b1, 1'b0, 8'h01, 8'h09, 16'h0000};
            DEC_RSP_L1:        d = '{1'b1, 1'b0, 8'h02, 8'h04, 16'h0000};
            DEC_ADV_CAP:       d = '{1'b1, 1'b1, 8'h05, 8'h02, 16'h0001};
            default:           d = '0;
        endcase
        return d;
    endfunction

    // cp covers the header with both parity bits still zero; dp is supplied by the caller.
    function automatic logic [63:0] sb_build_hdr(input sb_dec_t d, input logic dp);
        logic [63:0] h;
        h        = '0;
        h[4:0]   = d.has_data ? MSG_DATA : MSG_NODATA;
        h[21:14] = d.msgcode;
        h[31:29] = SB_SRCID;
        h[39:32] = d.msgsubcode;
        h[55:40] = d.msginfo;
        h[58:56] = SB_DSTID;
        h[62]    = ^h;
        h[63]    = dp;
        return h;
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_tx_serializer.sv
// Holds one 128-bit sideband packet and walks it out N bits per beat, LSB first.
// Latency: beat 0 is presented the cycle after i_load.
// Backpressure: none; the owner advances only while it has a credit-cleared packet in flight.
module ucie_ctl_sb_tx_serializer #(
    parameter int N  = 32,
    parameter int BW = $clog2(128 / N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [127:0]  i_pkt,
    input  logic          i_adv,
    output logic [N-1:0]  o_beat,
    output logic [BW-1:0] o_beat_idx
);

    localparam int BEATS = 128 / N;

    logic [BEATS-1:0][N-1:0] pkt_q;
    logic [BW-1:0]           cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pkt_q <= '0;
            cnt_q <= '0;
        end else if (i_load) begin
            pkt_q <= i_pkt;
            cnt_q <= '0;
        end else if (i_adv) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The low bits index the beat within a phase; the MSB selects header vs data.
    assign o_beat     = pkt_q[cnt_q];
    assign o_beat_idx = cnt_q;

endmodule

// File: rtl/ucie_ctl_sb_tx.sv
// RDI sideband transmitter: decode lookup, header/data build with parity, credit-gated serialization.
// Latency: first beat on o_lp_cfg the cycle after accept; packets go out without bubbles.
// Backpressure: o_lp_sb_ready only in IDLE with a credit held; one credit per packet, returned by i_pl_cfg_crd.
module ucie_ctl_sb_tx
    import ucie_ctl_sb_pkg::*;
#(
    parameter int N        = 32,
    parameter int CRD_INIT = 4,
    parameter int CRD_W    = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid_lp_sb,
    input  logic [4:0]   i_lp_sb_decode,
    input  logic [31:0]  i_lp_adv_cap_value,
    output logic         o_lp_sb_ready,
    input  logic         i_pl_cfg_crd,
    output logic         o_lp_cfg_vld,
    output logic [N-1:0] o_lp_cfg,
    output logic         o_sb_encode_error,
    output logic         o_tx_busy
);

    localparam int BPP = 64 / N;
    localparam int BW  = $clog2(128 / N);
    localparam logic [BW-1:0]    LAST_HDR  = BW'(BPP - 1);
    localparam logic [BW-1:0]    LAST_DATA = BW'(2 * BPP - 1);
    localparam logic [CRD_W-1:0] CRD_MAX   = '1;

    sb_state_e        state_q;
    logic [CRD_W-1:0] credit_q;
    logic             has_data_q;
    logic             enc_err_q;

    sb_dec_t          dec;
    logic             accept;
    logic             accept_ok;
    logic             accept_bad;
    logic [63:0]      hdr;
    logic [63:0]      data;
    logic [BW-1:0]    beat_idx;
    logic [N-1:0]     beat;

    assign dec        = sb_decode(i_lp_sb_decode);
    assign data       = {32'h0, i_lp_adv_cap_value};
    assign hdr        = sb_build_hdr(dec, dec.has_data & (^data));

    // Ready is gated by i_rst so no request can be taken while reset is held.
    assign o_lp_sb_ready = i_rst && (state_q == ST_IDLE) && (credit_q != '0);
    assign accept        = i_valid_lp_sb && o_lp_sb_ready;
    assign accept_ok     = accept && dec.supported;
    assign accept_bad    = accept && !dec.supported;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            has_data_q <= 1'b0;
            enc_err_q  <= 1'b0;
        end else begin
            enc_err_q <= accept_bad;
            case (state_q)
                ST_IDLE: begin
                    if (accept_ok) begin
                        state_q    <= ST_HDR;
                        has_data_q <= dec.has_data;
                    end
                end
                ST_HDR: begin
                    if (beat_idx == LAST_HDR) begin
                        state_q <= has_data_q ? ST_DATA : ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (beat_idx == LAST_DATA) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A return and a consume in the same cycle cancel; returns beyond the counter max are dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            credit_q <= CRD_W'(CRD_INIT);
        end else begin
            case ({i_pl_cfg_crd, accept_ok})
                2'b10: begin
                    if (credit_q != CRD_MAX) begin
                        credit_q <= credit_q + 1'b1;
                    end
                end
                2'b01:   credit_q <= credit_q - 1'b1;
                default: credit_q <= credit_q;
            endcase
        end
    end

    ucie_ctl_sb_tx_serializer #(
        .N  (N),
        .BW (BW)
    ) u_ser (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (accept_ok),
        .i_pkt      ({data, hdr}),
        .i_adv      (state_q != ST_IDLE),
        .o_beat     (beat),
        .o_beat_idx (beat_idx)
    );

    assign o_lp_cfg_vld      = (state_q != ST_IDLE);
    assign o_tx_busy         = (state_q != ST_IDLE);
    assign o_lp_cfg          = o_lp_cfg_vld ? beat : '0;
    assign o_sb_encode_error = enc_err_q;

endmodule

// File: tb/tb_ucie_ctl_sb_tx.sv
// Directed scoreboard bench for ucie_ctl_sb_tx at N=16, CRD_INIT=2.
// Expected headers below are hand-assembled from the field layout and decode table.
module tb_ucie_ctl_sb_tx;

    localparam int N        = 16;
    localparam int CRD_INIT = 2;
    localparam int CRD_W    = 3;
    localparam int BPP      = 64 / N;

    // {phase1, phase0}; cp = bit 62, dp = bit 63
    localparam logic [63:0] HDR_D1  = 64'h4500_0001_2000_4012;
    localparam logic [63:0] HDR_D2  = 64'h4500_0004_2000_4012;
    localparam logic [63:0] HDR_D3  = 64'h4500_0001_2000_8012;
    localparam logic [63:0] HDR_CAP_DP0 = 64'h4500_0102_2001_401B;
    localparam logic [63:0] HDR_CAP_DP1 = 64'hC500_0102_2001_401B;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         i_valid_lp_sb = 1'b0;
    logic [4:0]   i_lp_sb_decode = '0;
    logic [31:0]  i_lp_adv_cap_value = '0;
    logic         o_lp_sb_ready;
    logic         i_pl_cfg_crd = 1'b0;
    logic         o_lp_cfg_vld;
    logic [N-1:0] o_lp_cfg;
    logic         o_sb_encode_error;
    logic         o_tx_busy;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];
    logic         err_exp = 1'b0;

    always #5 i_clk = ~i_clk;

    ucie_ctl_sb_tx #(
        .N        (N),
        .CRD_INIT (CRD_INIT),
        .CRD_W    (CRD_W)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_valid_lp_sb      (i_valid_lp_sb),
        .i_lp_sb_decode     (i_lp_sb_decode),
        .i_lp_adv_cap_value (i_lp_adv_cap_value),
        .o_lp_sb_ready      (o_lp_sb_ready),
        .i_pl_cfg_crd       (i_pl_cfg_crd),
        .o_lp_cfg_vld       (o_lp_cfg_vld),
        .o_lp_cfg           (o_lp_cfg),
        .o_sb_encode_error  (o_sb_encode_error),
        .o_tx_busy          (o_tx_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every beat must match the head of the scoreboard; idle cycles must be quiet.
    initial begin
        logic [N-1:0] e;
        forever begin
            @(negedge i_clk);
            check("vld", o_lp_cfg_vld, exp_q.size() != 0);
            check("busy", o_tx_busy, exp_q.size() != 0);
            check("enc_err", o_sb_encode_error, err_exp);
            if (exp_q.size() != 0 && o_lp_cfg_vld) begin
                e = exp_q.pop_front();
                check("beat", o_lp_cfg, e);
            end else if (!o_lp_cfg_vld) begin
                check("idle_data", o_lp_cfg, '0);
            end
        end
    end

    task automatic push_pkt(input logic [63:0] hdr, input bit has_data, input logic [31:0] cap);
        logic [127:0] p;
        p = {32'h0, cap, hdr};
        for (int k = 0; k < (has_data ? 2 : 1) * BPP; k++) exp_q.push_back(p[k*N +: N]);
    endtask

    // Presents a request until accepted; the expected packet is queued on the accept edge.
    task automatic send(input logic [4:0] dec, input logic [31:0] cap, input logic [63:0] hdr,
                        input bit has_data, input bit crd_same, input bit sup);
        bit ok;
        ok = 1'b0;
        @(posedge i_clk); #1;
        i_valid_lp_sb = 1'b1;
        i_lp_sb_decode = dec;
        i_lp_adv_cap_value = cap;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge i_clk);
            if (o_lp_sb_ready) begin
                i_pl_cfg_crd = crd_same;
                @(posedge i_clk); #1;
                i_valid_lp_sb = 1'b0;
                i_pl_cfg_crd = 1'b0;
                ok = 1'b1;
                if (sup) begin
                    push_pkt(hdr, has_data, cap);
                end else begin
                    err_exp = 1'b1;
                    @(posedge i_clk); #1;
                    err_exp = 1'b0;
                end
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: decode %0d never accepted, required accept within 50 cycles", dec);
            i_valid_lp_sb = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(negedge i_clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic crd_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_pl_cfg_crd = 1'b1;
            @(posedge i_clk); #1;
            i_pl_cfg_crd = 1'b0;
        end
    endtask

    task automatic check_ready(input string name, input logic exp);
        @(negedge i_clk);
        check(name, o_lp_sb_ready, exp);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_ready", o_lp_sb_ready, 1'b0);
        check("rst_vld", o_lp_cfg_vld, 1'b0);
        check("rst_data", o_lp_cfg, '0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        check_ready("ready_after_rst", 1'b1);

        // No-data message; cap value must not leak into the packet. Credits 2 -> 1.
        send(5'd1, 32'hDEAD_BEEF, HDR_D1, 1'b0, 1'b0, 1'b1);
        wait_idle();

        // Capability with data, credit returned on the accept cycle: count stays 1.
        send(5'd8, 32'hA5A5_0F0F, HDR_CAP_DP0, 1'b1, 1'b1, 1'b1);
        wait_idle();
        check_ready("ready_after_overlap", 1'b1);
        send(5'd2, 32'h0, HDR_D2, 1'b0, 1'b0, 1'b1);
        wait_idle();
        check_ready("ready_no_credit", 1'b0);

        // Request held with no credit, then released by a single return.
        @(posedge i_clk); #1;
        i_valid_lp_sb = 1'b1;
        i_lp_sb_decode = 5'd3;
        i_lp_adv_cap_value = 32'h0;
        repeat (3) check_ready("held_ready", 1'b0);
        @(posedge i_clk); #1;
        i_pl_cfg_crd = 1'b1;
        @(posedge i_clk); #1;
        i_pl_cfg_crd = 1'b0;
        check_ready("ready_after_return", 1'b1);
        @(posedge i_clk); #1;
        i_valid_lp_sb = 1'b0;
        push_pkt(HDR_D3, 1'b0, 32'h0);
        wait_idle();
        check_ready("ready_drained_again", 1'b0);

        // Unsupported decodes drop with a one-cycle error and keep both credits.
        crd_pulse(2);
        send(5'd31, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        send(5'd0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        check_ready("ready_after_unsup", 1'b1);
        send(5'd1, 32'h0, HDR_D1, 1'b0, 1'b0, 1'b1);
        send(5'd1, 32'h0, HDR_D1, 1'b0, 1'b0, 1'b1);
        wait_idle();
        check_ready("ready_unsup_kept_credit", 1'b0);

        // Nine returns from zero saturate at seven.
        crd_pulse(9);
        send(5'd8, 32'h1234_5678, HDR_CAP_DP1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) send(5'd1, 32'h0, HDR_D1, 1'b0, 1'b0, 1'b1);
        wait_idle();
        check_ready("ready_after_sat", 1'b0);

        // Reset during beat 1 of a data packet aborts it and restores CRD_INIT.
        crd_pulse(1);
        send(5'd8, 32'hA5A5_0F0F, HDR_CAP_DP0, 1'b1, 1'b0, 1'b1);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        exp_q.delete();
        check_ready("ready_in_rst", 1'b0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        check_ready("ready_post_abort", 1'b1);
        send(5'd2, 32'h0, HDR_D2, 1'b0, 1'b0, 1'b1);
        send(5'd3, 32'h0, HDR_D3, 1'b0, 1'b0, 1'b1);
        wait_idle();
        check_ready("ready_crd_init_used", 1'b0);

        repeat (2) @(negedge i_clk);
        check("leftover_beats", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
